// File: rtl/piso_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : piso_rr_scheduler
// Brief    : Round-robin arbiter sharing one parallel-in/serial-out shifter
//            among NREQ requesters; words leave MSB first. Define
//            PISO_PARITY_EN to append an even-parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module piso_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       ack,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_last
);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [1:0]     S_IDLE     = 2'd0;
    localparam logic [1:0]     S_LOAD     = 2'd1;
    localparam logic [1:0]     S_SHIFT    = 2'd2;
    localparam logic [CW-1:0]  C_LAST_BIT = CW'(FRAME - 1);
    localparam logic [IDW-1:0] C_PTR_INIT = IDW'(NREQ - 1);

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_last_gnt;
    logic [IDW-1:0]   r_gnt_id;
    logic [NREQ-1:0]  r_ack;
    logic             r_busy;
    logic             r_dout_valid;
    logic             r_dout_last;
    logic [FRAME-1:0] r_sr;
    logic [CW-1:0]    r_cnt;

    logic [NREQ-1:0]  w_rot;
    logic             w_found;
    logic [IDW-1:0]   w_arb_id;
    logic [WIDTH-1:0] w_word;
    logic [FRAME-1:0] w_frame;
    logic [1:0]       w_state_nxt;
    logic [IDW-1:0]   w_gnt_nxt;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [FRAME-1:0] w_sr_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    // Rotate requests so bit 0 is the requester right after the last grant.
    always_comb begin
        w_rot    = NREQ'({req, req} >> (int'(r_last_gnt) + 1));
        w_found  = 1'b0;
        w_arb_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found  = 1'b1;
                w_arb_id = IDW'((int'(r_last_gnt) + 1 + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt_id == IDW'(i)) begin
                w_word = data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PISO_PARITY_EN
    assign w_frame = {w_word, ^w_word};
`else
    assign w_frame = w_word;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_ptr_nxt   = r_last_gnt;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_LOAD;
                    w_gnt_nxt   = w_arb_id;
                    w_ptr_nxt   = w_arb_id;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
                w_sr_nxt    = w_frame;
                w_cnt_nxt   = '0;
            end
            S_SHIFT: begin
                w_sr_nxt  = r_sr << 1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST_BIT) begin
                    w_cnt_nxt = '0;
                    if (|req) begin
                        w_state_nxt = S_LOAD;
                        w_gnt_nxt   = w_arb_id;
                        w_ptr_nxt   = w_arb_id;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_gnt   <= C_PTR_INIT;
            r_gnt_id     <= '0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_sr         <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_gnt   <= w_ptr_nxt;
            r_gnt_id     <= w_gnt_nxt;
            r_ack        <= (w_state_nxt == S_LOAD) ? (NREQ'(1) << w_gnt_nxt) : '0;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_dout_valid <= (w_state_nxt == S_SHIFT);
            r_dout_last  <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == C_LAST_BIT);
            r_sr         <= w_sr_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // The shifter drains to zero, so its MSB already reads 0 outside SHIFT.
    assign dout       = r_sr[FRAME-1];
    assign ack        = r_ack;
    assign gnt_id     = r_gnt_id;
    assign busy       = r_busy;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_rr_scheduler
// Brief    : Directed bench for piso_rr_scheduler with a cycle-position model
//            of each grant/frame; honours PISO_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] data  = '0;
    logic [NREQ-1:0]       ack;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;
    logic                  dout;
    logic                  dout_valid;
    logic                  dout_last;

    piso_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack),
        .gnt_id(gnt_id), .busy(busy), .dout(dout), .dout_valid(dout_valid),
        .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   grants[$];
    int   ack_cyc[$];
    logic bits[$];

    // Model: a transaction is LOAD (position 0) followed by FRAME bit slots.
    logic             m_act  = 1'b0;
    int               m_p    = 0;
    int               m_g    = 0;
    int               m_ptr  = NREQ - 1;
    int               m_gid  = 0;
    logic [WIDTH-1:0] m_word = '0;

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int off = 1; off <= NREQ; off++)
            if (r[IDW'((ptr + off) % NREQ)]) return (ptr + off) % NREQ;
        return 0;
    endfunction

    function automatic logic fbit(input logic [WIDTH-1:0] w, input int j);
        logic [WIDTH-1:0] t;
        t = w << j;
        return (j < WIDTH) ? t[WIDTH-1] : ^w;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : p_model
        if (reset) begin
            m_act <= 1'b0;
            m_p   <= 0;
            m_ptr <= NREQ - 1;
            m_gid <= 0;
        end else if (m_act && m_p < FRAME) begin
            if (m_p == 0)
                for (int i = 0; i < NREQ; i++)
                    if (i == m_g) m_word <= data[i*WIDTH +: WIDTH];
            m_p <= m_p + 1;
        end else if (req != '0) begin
            m_act <= 1'b1;
            m_p   <= 0;
            m_g   <= pick(req, m_ptr);
            m_ptr <= pick(req, m_ptr);
            m_gid <= pick(req, m_ptr);
        end else begin
            m_act <= 1'b0;
            m_p   <= 0;
        end
    end

    always @(negedge clk) begin : p_compare
        logic [NREQ-1:0] e_ack;
        logic            e_valid;
        e_ack   = (m_act && m_p == 0) ? (NREQ'(1) << m_g) : '0;
        e_valid = m_act && (m_p >= 1);
        check("ack",        int'(ack),        int'(e_ack));
        check("gnt_id",     int'(gnt_id),     m_gid);
        check("busy",       int'(busy),       int'(m_act));
        check("dout_valid", int'(dout_valid), int'(e_valid));
        check("dout",       int'(dout),       e_valid ? int'(fbit(m_word, m_p - 1)) : 0);
        check("dout_last",  int'(dout_last),  int'(m_act && m_p == FRAME));
        if (ack != '0) begin
            for (int i = 0; i < NREQ; i++) if (ack[i]) grants.push_back(i);
            ack_cyc.push_back(cyc);
        end
        if (dout_valid) bits.push_back(dout);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        grants.delete();
        ack_cyc.delete();
        bits.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int idx);
        int n;
        n = 0;
        while (!ack[idx] && n < 40) begin
            tick();
            n++;
        end
        if (!ack[idx]) check("timeout_ack", 0, 1);
    endtask

    task automatic wait_grants(input int cnt);
        int n;
        n = 0;
        while (grants.size() < cnt && n < 80) begin
            tick();
            n++;
        end
        if (grants.size() < cnt) check("timeout_grants", grants.size(), cnt);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) check("timeout_idle", 1, 0);
        tick();
    endtask

    function automatic int gnt_at(input int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    task automatic check_bits(input string nm, input logic [15:0] exp, input int n);
        check({nm, "_len"}, bits.size(), n);
        for (int i = 0; i < n; i++)
            check(nm, (i < bits.size()) ? int'(bits[i]) : -1, int'(exp[n-1-i]));
    endtask

    initial begin : p_stim
        logic [15:0] e1;
        logic [15:0] e4;
`ifdef PISO_PARITY_EN
        e1 = 16'b10010;
        e4 = 16'b11101_01010;
`else
        e1 = 16'b1001;
        e4 = 16'b1110_0101;
`endif
        repeat (3) tick();
        check("rst_ack",   int'(ack), 0);
        check("rst_gnt",   int'(gnt_id), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_dout",  int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_last",  int'(dout_last), 0);
        reset = 1'b0;

        // Single requester
        clear();
        data[2*WIDTH +: WIDTH] = 4'b1001;
        req = 4'b0100;
        wait_ack(2);
        tick();
        req = '0;
        repeat (FRAME + 4) tick();
        check("t1_ngrant", grants.size(), 1);
        check("t1_gnt", gnt_at(0), 2);
        check("t1_gnt_id", int'(gnt_id), 2);
        check_bits("t1_bits", e1, FRAME);

        // Fairness under continuous requests
        do_reset();
        clear();
        data = 16'h8C3A;
        req  = 4'b1111;
        wait_grants(5);
        req = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) check("t2_order", gnt_at(i), i % NREQ);
        for (int i = 0; i < 4; i++)
            check("t2_spacing", (i + 1 < ack_cyc.size()) ? ack_cyc[i+1] - ack_cyc[i] : -1, FRAME + 1);

        // Pointer rotation
        do_reset();
        data = 16'h5A3C;
        req  = 4'b0010;
        wait_ack(1);
        tick();
        req = '0;
        wait_idle();
        clear();
        req = 4'b0011;
        wait_grants(2);
        req = '0;
        wait_idle();
        check("t3_first", gnt_at(0), 0);
        check("t3_second", gnt_at(1), 1);

        // Back-to-back frames
        do_reset();
        clear();
        data = '0;
        data[3*WIDTH +: WIDTH] = 4'b1110;
        req = 4'b1000;
        wait_ack(3);
        repeat (2) tick();
        data[0 +: WIDTH] = 4'b0101;
        req[0] = 1'b1;
        wait_ack(0);
        tick();
        req = '0;
        wait_idle();
        check("t4_g0", gnt_at(0), 3);
        check("t4_g1", gnt_at(1), 0);
        check("t4_gap", (ack_cyc.size() > 1) ? ack_cyc[1] - ack_cyc[0] : -1, FRAME + 1);
        check_bits("t4_bits", e4, 2 * FRAME);

        // Reset mid-frame
        do_reset();
        clear();
        data[3*WIDTH +: WIDTH] = 4'b1111;
        req = 4'b1000;
        wait_ack(3);
        repeat (2) tick();
        check("t5_nbits", bits.size(), 2);
        reset = 1'b1;
        req   = '0;
        tick();
        check("t5_dout", int'(dout), 0);
        check("t5_valid", int'(dout_valid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_ack", int'(ack), 0);
        reset = 1'b0;
        clear();
        req = 4'b1111;
        wait_grants(1);
        req = '0;
        wait_idle();
        check("t5_first", gnt_at(0), 0);

`ifdef PISO_PARITY_EN
        do_reset();
        clear();
        data[0 +: WIDTH] = 4'b1011;
        req = 4'b0001;
        wait_ack(0);
        tick();
        req = '0;
        wait_idle();
        check_bits("t6_par1", 16'b10111, 5);
        clear();
        data[WIDTH +: WIDTH] = 4'b1001;
        req = 4'b0010;
        wait_ack(1);
        tick();
        req = '0;
        wait_idle();
        check_bits("t6_par0", 16'b10010, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
